// File: rtl/fpadd_issue_ctrl.sv
// Issue controller for an external pipelined FP32 adder: forwards operand pairs,
// tracks them in flight, and buffers sums in a credit-protected show-ahead FIFO.
module fpadd_issue_ctrl #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + LATENCY + 2);

  logic [LATENCY:0] r_vld;
  logic [31:0]      r_add_a;
  logic [31:0]      r_add_b;
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_outstanding;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  // Every accepted pair owns a FIFO slot from accept until pop, so a write can never overflow.
  assign w_outstanding = CW'(r_count) + w_inflight;
  assign in_ready      = w_outstanding < CW'(DEPTH);

  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_vld[LATENCY];
  assign w_pop     = out_valid && out_ready;

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign busy      = (w_inflight != '0) || (r_count != '0);
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;

  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld    <= '0;
      r_add_a  <= 32'h0;
      r_add_b  <= 32'h0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_vld   <= {r_vld[LATENCY-1:0], w_accept};
      r_add_a <= w_accept ? in_a : 32'h0;
      r_add_b <= w_accept ? in_b : 32'h0;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; out_valid gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= add_out;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == (AW+1)'(DEPTH))));

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Bench for fpadd_issue_ctrl: a pipelined FP32 adder model feeds the DUT, and a
// queue of outstanding sums with visibility times predicts every output.
module tb_fpadd_issue_ctrl;

  localparam int LAT  = 3;
  localparam int DEP  = 4;
  localparam int SDEP = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_a, in_b, add_a, add_b, add_out, out_data;

  // Second instance deep enough to cover the accept-to-pop-to-ready round trip.
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [31:0] s_in_a, s_in_b, s_add_a, s_add_b, s_add_out, s_out_data;

  typedef struct { logic [31:0] sum; int vis; } item_t;
  item_t q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  fpadd_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_out(add_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  fpadd_issue_ctrl #(.LATENCY(LAT), .DEPTH(SDEP)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .add_a(s_add_a), .add_b(s_add_b), .add_out(s_add_out),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy));

  function automatic real fp32_to_real(input logic [31:0] f);
    if (f[30:0] == 31'h0) return 0.0;
    return $bitstoreal({f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] d;
    logic [31:0] f;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return 32'h0;
    f = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && ((d[27:0] != 28'h0) || d[29])) f = f + 32'd1;
    return f;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] f;
    f = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    if ($urandom_range(0, 9) == 0) f = 32'h0;
    return f;
  endfunction

  // Downstream adders: capture operands each edge, sum appears LAT edges later.
  logic [31:0] pipe [LAT];
  logic [31:0] s_pipe [LAT];
  always @(posedge clk) begin
    pipe[0]   <= fp_add(add_a, add_b);
    s_pipe[0] <= fp_add(s_add_a, s_add_b);
    for (int i = 1; i < LAT; i++) begin
      pipe[i]   <= pipe[i-1];
      s_pipe[i] <= s_pipe[i-1];
    end
  end
  assign add_out   = pipe[LAT-1];
  assign s_add_out = s_pipe[LAT-1];

  // Model view after the most recent edge.
  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
    return q[0].vis <= cyc;
  endfunction
  function automatic bit m_ready();
    return q.size() < DEP;
  endfunction
  function automatic bit m_busy();
    return q.size() != 0;
  endfunction
  function automatic logic [31:0] m_head();
    if (q.size() == 0) return 32'h0;
    return q[0].sum;
  endfunction

  // Sample handshakes before the edge, update the model, advance one cycle.
  task automatic tick(output bit acc, output bit pop, output logic [31:0] head,
                      output bit exp_ok, output logic [31:0] exp_head);
    item_t it;
    acc      = in_valid && in_ready;
    pop      = out_valid && out_ready;
    head     = out_data;
    exp_ok   = m_valid();
    exp_head = m_head();
    if (pop && q.size() != 0) void'(q.pop_front());
    if (acc) begin
      it.sum = fp_add(in_a, in_b);
      it.vis = cyc + LAT + 2;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    bit acc, pop, ok;
    logic [31:0] hd, eh, a, b;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 32'h0; in_b = 32'h0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_a = 32'h0; s_in_b = 32'h0;
    #2;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++; $display("FAIL reset_flags: got v/b/r=%b%b%b expected 001", out_valid, busy, in_ready);
    end
    checks++;
    if ({out_data, add_a, add_b} !== 96'h0) begin
      failures++; $display("FAIL reset_data: got out=%h a=%h b=%h expected zeros", out_data, add_a, add_b);
    end
    a = rand_fp(); b = rand_fp();
    reset = 1'b0; in_valid = 1'b1; in_a = a; in_b = b;
    checks++;
    if ({out_valid, busy, in_ready, out_data} !== {3'b001, 32'h0}) begin
      failures++; $display("FAIL release_flags: got v/b/r=%b%b%b out=%h expected 001 0", out_valid, busy, in_ready, out_data);
    end
    tick(acc, pop, hd, ok, eh);
    in_valid = 1'b0;
    checks++;
    if (!acc || add_a !== a || add_b !== b) begin
      failures++; $display("FAIL first_accept: got acc=%b a=%h b=%h expected 1 %h %h", acc, add_a, add_b, a, b);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && q.size() != 0; c++) begin
      tick(acc, pop, hd, ok, eh);
      if (pop) begin
        checks++;
        if (!ok || hd !== eh) begin
          failures++; $display("FAIL first_result: got %h expected %h (model ready %b)", hd, eh, ok);
        end
      end
    end
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL first_drain: got pending=%0d busy=%b expected 0 0", q.size(), busy);
    end
  endtask

  task automatic test_single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expv);
    bit acc, pop, ok;
    logic [31:0] hd, eh;
    out_ready = 1'b1; in_valid = 1'b1; in_a = a; in_b = b;
    tick(acc, pop, hd, ok, eh);
    in_valid = 1'b0;
    checks++;
    if (!acc || add_a !== a || add_b !== b) begin
      failures++; $display("FAIL %s_accept: got acc=%b a=%h b=%h expected 1 %h %h", name, acc, add_a, add_b, a, b);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(acc, pop, hd, ok, eh);
      if (k == 1) begin
        checks++;
        if ({add_a, add_b} !== 64'h0) begin
          failures++; $display("FAIL %s_idle_operands: got %h %h expected 0 0", name, add_a, add_b);
        end
      end
      if (k < 4) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++; $display("FAIL %s_early_valid: got out_valid=%b at cycle %0d expected 0", name, out_valid, k);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== expv) begin
          failures++; $display("FAIL %s_result: got v=%b data=%h expected 1 %h", name, out_valid, out_data, expv);
        end
      end
    end
    tick(acc, pop, hd, ok, eh);
    checks++;
    if (!pop || !ok || hd !== eh || hd !== expv) begin
      failures++; $display("FAIL %s_pop: got pop=%b data=%h expected 1 %h", name, pop, hd, expv);
    end
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++; $display("FAIL %s_idle: got v/b=%b%b expected 00", name, out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    bit acc, pop, ok;
    logic [31:0] hd, eh;
    logic [31:0] pa [8];
    logic [31:0] pb [8];
    int idx = 0, pops = 0, first_pop = -1, first_acc = -1;
    for (int i = 0; i < 8; i++) begin
      pa[i] = rand_fp(); pb[i] = rand_fp();
    end
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_a = pa[idx]; in_b = pb[idx];
      tick(acc, pop, hd, ok, eh);
      if (acc) idx++;
      checks++;
      if ({out_valid, in_ready, busy} !== {m_valid(), m_ready(), m_busy()}) begin
        failures++; $display("FAIL bp_fill_status: got v/r/b=%b%b%b expected %b%b%b",
                             out_valid, in_ready, busy, m_valid(), m_ready(), m_busy());
      end
    end
    checks++;
    if (idx != DEP || in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_accept_count: got accepts=%0d in_ready=%b expected %0d 0", idx, in_ready, DEP);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== fp_add(pa[0], pb[0])) begin
      failures++; $display("FAIL bp_head: got v=%b data=%h expected 1 %h", out_valid, out_data, fp_add(pa[0], pb[0]));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && pops < 8; c++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_a = pa[idx]; in_b = pb[idx];
      end
      tick(acc, pop, hd, ok, eh);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (pop) begin
        if (first_pop < 0) first_pop = cyc;
        pops++;
        checks++;
        if (!ok || hd !== eh) begin
          failures++; $display("FAIL bp_order: got %h expected %h (model ready %b)", hd, eh, ok);
        end
      end
      checks++;
      if ({out_valid, in_ready, busy} !== {m_valid(), m_ready(), m_busy()}) begin
        failures++; $display("FAIL bp_drain_status: got v/r/b=%b%b%b expected %b%b%b",
                             out_valid, in_ready, busy, m_valid(), m_ready(), m_busy());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pops != 8 || idx != 8) begin
      failures++; $display("FAIL bp_totals: got pops=%0d accepts=%0d expected 8 8", pops, idx);
    end
    checks++;
    if (first_pop < 0 || first_acc <= first_pop) begin
      failures++; $display("FAIL bp_credit_timing: got accept edge %0d pop edge %0d expected accept after pop", first_acc, first_pop);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] sq[$];
    logic [31:0] hd, ex;
    bit acc, pop;
    int n_acc = 0, n_acc16 = 0, pops = 0, gaps = 0, first_v = -1;
    s_out_ready = 1'b1;
    for (int t = 1; t <= 40 && pops < 16; t++) begin
      s_in_valid = (n_acc < 16);
      s_in_a = rand_fp(); s_in_b = rand_fp();
      acc = s_in_valid && s_in_ready;
      pop = s_out_valid && s_out_ready;
      hd  = s_out_data;
      if (pop) begin
        pops++;
        checks++;
        if (sq.size() == 0) begin
          failures++; $display("FAIL stream_order: got unexpected result %h expected none", hd);
        end else begin
          ex = sq.pop_front();
          if (hd !== ex) begin
            failures++; $display("FAIL stream_order: got %h expected %h", hd, ex);
          end
        end
      end
      if (acc) begin
        sq.push_back(fp_add(s_in_a, s_in_b));
        n_acc++;
        if (t <= 16) n_acc16++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_out_valid && first_v < 0) first_v = t;
      else if (first_v >= 0 && pops < 16 && !s_out_valid) gaps++;
    end
    s_in_valid = 1'b0;
    checks++;
    if (n_acc16 != 16) begin
      failures++; $display("FAIL stream_rate: got %0d accepts in 16 cycles expected 16", n_acc16);
    end
    checks++;
    if (pops != 16 || sq.size() != 0) begin
      failures++; $display("FAIL stream_count: got pops=%0d left=%0d expected 16 0", pops, sq.size());
    end
    checks++;
    if (first_v != LAT + 2 || gaps != 0) begin
      failures++; $display("FAIL stream_continuity: got first_valid=%0d gaps=%0d expected %0d 0", first_v, gaps, LAT + 2);
    end
    checks++;
    if (s_busy !== 1'b0) begin
      failures++; $display("FAIL stream_idle: got busy=%b expected 0", s_busy);
    end
  endtask

  task automatic test_reset_midflight();
    bit acc, pop, ok;
    logic [31:0] hd, eh;
    int n = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 10 && n < 3; c++) begin
      in_a = rand_fp(); in_b = rand_fp();
      tick(acc, pop, hd, ok, eh);
      if (acc) n++;
    end
    in_valid = 1'b0;
    tick(acc, pop, hd, ok, eh);
    tick(acc, pop, hd, ok, eh);
    checks++;
    if (n != 3 || busy !== 1'b1) begin
      failures++; $display("FAIL midflight_setup: got accepts=%0d busy=%b expected 3 1", n, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    checks++;
    if ({out_valid, busy, in_ready, out_data, add_a} !== {3'b001, 64'h0}) begin
      failures++; $display("FAIL midflight_async: got v/b/r=%b%b%b out=%h a=%h expected 001 0 0",
                           out_valid, busy, in_ready, out_data, add_a);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick(acc, pop, hd, ok, eh);
      checks++;
      if ({out_valid, busy, in_ready} !== 3'b001) begin
        failures++; $display("FAIL midflight_stale: got v/b/r=%b%b%b data=%h expected 001", out_valid, busy, in_ready, out_data);
      end
    end
  endtask

  task automatic test_push_pop_full();
    bit acc, pop, ok, pushn;
    logic [31:0] hd, eh;
    int hits = 0, fcnt;
    in_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      in_a = rand_fp(); in_b = rand_fp();
      out_ready = ($urandom_range(0, 2) == 0);
      fcnt = 0; pushn = 1'b0;
      foreach (q[i]) begin
        if (q[i].vis <= cyc) fcnt++;
        if (q[i].vis == cyc + 1) pushn = 1'b1;
      end
      if (fcnt == DEP - 1 && pushn && out_valid && out_ready) hits++;
      tick(acc, pop, hd, ok, eh);
      if (pop) begin
        checks++;
        if (!ok || hd !== eh) begin
          failures++; $display("FAIL full_order: got %h expected %h (model ready %b)", hd, eh, ok);
        end
      end
      checks++;
      if ({out_valid, in_ready, busy} !== {m_valid(), m_ready(), m_busy()}) begin
        failures++; $display("FAIL full_status: got v/r/b=%b%b%b expected %b%b%b",
                             out_valid, in_ready, busy, m_valid(), m_ready(), m_busy());
      end
      if (m_valid()) begin
        checks++;
        if (out_data !== m_head()) begin
          failures++; $display("FAIL full_head: got %h expected %h", out_data, m_head());
        end
      end
    end
    checks++;
    if (hits == 0) begin
      failures++; $display("FAIL full_push_pop_hits: got %0d expected >0", hits);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      tick(acc, pop, hd, ok, eh);
      if (pop) begin
        checks++;
        if (!ok || hd !== eh) begin
          failures++; $display("FAIL full_drain: got %h expected %h (model ready %b)", hd, eh, ok);
        end
      end
    end
    checks++;
    if (q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL full_end: got pending=%0d busy=%b v=%b expected 0 0 0", q.size(), busy, out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op("single", 32'h3F800000, 32'h40000000, 32'h40400000);
    test_single_op("cancel", 32'h40400000, 32'hC0400000, 32'h00000000);
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    test_push_pop_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpadd_issue_ctrl.md
FPADD_ISSUE_CTRL -- requirements
Module: fpadd_issue_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning the clock edges from the adder capturing add_a/add_b to add_out holding the sum.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of result FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit, operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit, operand pair can be accepted.
REQ-007 SHALL have ports in_a and in_b, input, 32 bits each, FP32 operands (normal or +0).
REQ-008 SHALL have ports add_a and add_b, output, 32 bits each, registered operands driving the downstream pipelined adder inputs.
REQ-009 SHALL have port add_out, input, 32 bits, the adder result.
REQ-010 SHALL have port out_valid, output, 1 bit, the FIFO head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit, the consumer takes the head.
REQ-012 SHALL have port out_data, output, 32 bits, the FIFO head sum.
REQ-013 SHALL have port busy, output, 1 bit, any operation is in flight or the FIFO is non-empty.

Function
REQ-014 SHALL accept a pair on a rising edge where in_valid && in_ready; that edge loads add_a/add_b with in_a/in_b.
REQ-015 SHALL load add_a and add_b with 32'h0 on every edge without an accept.
REQ-016 SHALL track in-flight operations with a (LATENCY+1)-bit valid shift register; bit 0 is set on accept and the register shifts every edge.
REQ-017 SHALL write add_out into the FIFO on the edge where the MSB of the valid shift register is 1, which is LATENCY+1 edges after the accept edge.
REQ-018 SHALL compute in_ready = (fifo_count + inflight_count) < DEPTH from registered state only, with no combinational path from out_ready or in_valid.
REQ-019 SHALL reserve FIFO space at accept time (credit scheme) so a FIFO write never finds the FIFO full; an overflow is a design error.
REQ-020 SHALL present the FIFO head show-ahead: out_valid = (fifo_count != 0) and out_data = head entry.
REQ-021 SHALL pop the head on an edge with out_valid && out_ready; out_ready while empty has no effect.
REQ-022 SHALL handle a simultaneous write and pop with count unchanged, and the written entry available at its slot; when the FIFO is empty, the write becomes the head on the next cycle.
REQ-023 SHALL free space from a pop for in_ready only from the cycle after the pop.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; fifo_count ranges 0..DEPTH.
REQ-025 SHALL deliver results in acceptance order with no loss or duplication.
REQ-026 SHALL give a minimum accept-to-out_valid latency of LATENCY+1 cycles (4 at default) and sustain one accept per cycle while out_ready is held high.
REQ-027 SHALL compute busy = (inflight_count != 0) || (fifo_count != 0).

Reset
REQ-028 SHALL, on reset assertion, immediately clear add_a, add_b, the valid shift register, FIFO pointers, and fifo_count, without waiting for clk.
REQ-029 SHALL hold out_valid=0, busy=0, in_ready=1, and out_data=32'h0 while reset is asserted and after release.
REQ-030 SHALL discard in-flight operations when reset is asserted mid-operation; no results for them appear after release.
REQ-031 SHALL accept a pair on the first rising edge after reset deasserts.

Verification
REQ-032 SHALL cover single op: in_a=32'h3F800000, in_b=32'h40000000, out_ready=1 -> out_valid rises 4 cycles after accept with out_data=32'h40400000.
REQ-033 SHALL cover backpressure: out_ready=0, in_valid held with 8 distinct pairs -> exactly 4 accepted, then in_ready=0; then out_ready=1 -> 4 results in order, then remaining 4 accepted.
REQ-034 SHALL cover streaming: 16 back-to-back pairs with out_ready=1 -> 16 accepts in 16 cycles and 16 in-order results, with out_valid continuous after the first.
REQ-035 SHALL cover cancellation: in_a=32'h40400000, in_b=32'hC0400000 -> out_data=32'h00000000.
REQ-036 SHALL cover reset mid-flight: reset asserted 2 cycles after 3 accepts -> out_valid=0 and busy=0 immediately and after release; no stale results.
REQ-037 SHALL cover simultaneous push and pop at fifo_count=DEPTH-1 with random out_ready -> count is stable, a scoreboard matches, and no overflow assertion fires.
